// File: rtl/imm_gen_pipe.sv
// LEGv8 immediate generator feeding a 2-entry output FIFO of {imm, imm_err}.
// Illegal formats are passed through as flagged zero entries and tallied in a saturating counter.
module imm_gen_pipe #(
   parameter int DATA_W    = 64,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          instr,
   input  logic [2:0]           fmt,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    imm,
   output logic                 imm_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   // Entry layout: {imm, imm_err}; DATA_W must be 32 or 64.
   function automatic logic [DATA_W:0] gen_entry(input logic [31:0] w, input logic [2:0] f);
      logic [DATA_W-1:0] v;
      logic              e;
      logic [5:0]        sh;
      v  = '0;
      e  = 1'b0;
      sh = {w[22:21], 4'b0000};
      case (f)
         3'd0:    v = {{(DATA_W-12){1'b0}}, w[21:10]};
         3'd1:    v = {{(DATA_W-9){w[20]}}, w[20:12]};
         3'd2:    v = {{(DATA_W-28){w[25]}}, w[25:0], 2'b00};
         3'd3:    v = {{(DATA_W-21){w[23]}}, w[23:5], 2'b00};
         3'd4:    v = {{(DATA_W-16){1'b0}}, w[20:5]} << sh;
         default: e = 1'b1;
      endcase
      return {v, e};
   endfunction

   logic [1:0]           cnt_q, cnt_d;
   logic [DATA_W:0]      ent0_q, ent0_d;
   logic [DATA_W:0]      ent1_q, ent1_d;
   logic                 out_valid_q, out_valid_d;
   logic                 in_ready_q, in_ready_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic                 push, pop;
   logic [DATA_W:0]      new_ent;

   always_comb begin
      push        = in_valid && in_ready_q;
      pop         = out_valid_q && out_ready;
      new_ent     = gen_entry(instr, fmt);
      cnt_d       = cnt_q;
      ent0_d      = ent0_q;
      ent1_d      = ent1_q;
      err_cnt_d   = err_cnt_q;
      // Unused slots are kept at zero so an empty FIFO presents imm=0, imm_err=0.
      if (flush) begin
         cnt_d  = 2'd0;
         ent0_d = '0;
         ent1_d = '0;
      end else begin
         if (pop) begin
            ent0_d = ent1_q;
            ent1_d = '0;
            cnt_d  = cnt_q - 2'd1;
         end
         if (push) begin
            if (cnt_d == 2'd0) ent0_d = new_ent;
            else               ent1_d = new_ent;
            cnt_d = cnt_d + 2'd1;
         end
      end
      out_valid_d = (cnt_d != 2'd0);
      in_ready_d  = (cnt_d != 2'd2);
      if (push && (fmt > 3'd4) && (err_cnt_q != {ERR_CNT_W{1'b1}}))
         err_cnt_d = err_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= 2'd0;
         ent0_q      <= '0;
         ent1_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         cnt_q       <= cnt_d;
         ent0_q      <= ent0_d;
         ent1_q      <= ent1_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign imm       = ent0_q[DATA_W:1];
   assign imm_err   = ent0_q[0];
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized and directed bench for imm_gen_pipe; a queue-based reference model
// tracks the FIFO contents, in_ready and the saturating error count.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] instr = 32'd0;
   logic [2:0]  fmt = 3'd0;

   logic        in_ready, out_valid, imm_err;
   logic [63:0] imm;
   logic [7:0]  err_cnt;
   logic        in_ready32, out_valid32, imm_err32;
   logic [31:0] imm32;
   logic [7:0]  err_cnt32;

   int checks = 0;
   int errors = 0;

   logic [64:0] q[$];
   int          errc_m = 0;
   bit          rdy_m = 1'b0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.DATA_W(64), .ERR_CNT_W(8)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .fmt(fmt), .out_valid(out_valid), .out_ready(out_ready),
      .imm(imm), .imm_err(imm_err), .err_cnt(err_cnt)
   );

   imm_gen_pipe #(.DATA_W(32), .ERR_CNT_W(8)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
      .instr(instr), .fmt(fmt), .out_valid(out_valid32), .out_ready(out_ready),
      .imm(imm32), .imm_err(imm_err32), .err_cnt(err_cnt32)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference immediate computed with plain 64-bit arithmetic; the 32-bit
   // variant is simply the low half of this value.
   function automatic logic [64:0] ref_entry(input logic [31:0] ins, input logic [2:0] f);
      longint          v;
      longint unsigned x;
      x = {32'd0, ins};
      v = 0;
      case (f)
         3'd0: v = longint'((x >> 10) % 64'd4096);
         3'd1: begin
            v = longint'((x >> 12) % 64'd512);
            if (v >= 256) v = v - 512;
         end
         3'd2: begin
            v = longint'(x % 64'd67108864) * 4;
            if (v >= 134217728) v = v - 268435456;
         end
         3'd3: begin
            v = longint'((x >> 5) % 64'd524288) * 4;
            if (v >= 1048576) v = v - 2097152;
         end
         3'd4: v = longint'(((x >> 5) % 64'd65536) << (64'd16 * ((x >> 21) % 64'd4)));
         default: return {64'd0, 1'b1};
      endcase
      return {v, 1'b0};
   endfunction

   // Called at a falling edge: check outputs, apply inputs, advance the model,
   // then wait for the next falling edge.
   task automatic cycle(input bit iv, input logic [31:0] ins, input logic [2:0] f,
                        input bit ordy, input bit fl);
      logic [64:0] head;
      bit          push, pop;
      head = (q.size() > 0) ? q[0] : 65'd0;
      chk("in_ready",   64'(in_ready),    64'(rdy_m));
      chk("out_valid",  64'(out_valid),   64'(q.size() > 0));
      chk("imm",        imm,              head[64:1]);
      chk("imm_err",    64'(imm_err),     64'(head[0]));
      chk("err_cnt",    64'(err_cnt),     64'(errc_m));
      chk("in_ready32", 64'(in_ready32),  64'(rdy_m));
      chk("out_valid32",64'(out_valid32), 64'(q.size() > 0));
      chk("imm32",      64'(imm32),       64'(head[32:1]));
      chk("imm_err32",  64'(imm_err32),   64'(head[0]));
      chk("err_cnt32",  64'(err_cnt32),   64'(errc_m));
      in_valid  = iv;
      instr     = ins;
      fmt       = f;
      out_ready = ordy;
      flush     = fl;
      push = iv && rdy_m;
      pop  = (q.size() > 0) && ordy;
      if (push && (f > 3'd4) && (errc_m < 255)) errc_m++;
      if (fl) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back(ref_entry(ins, f));
      end
      rdy_m = (q.size() < 2);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_in_ready",  64'(in_ready),  64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_imm",       imm,            64'd0);
      chk("rst_imm_err",   64'(imm_err),   64'd0);
      chk("rst_err_cnt",   64'(err_cnt),   64'd0);
      rst_n = 1'b1;
      #1;
      chk("rdy_before_edge", 64'(in_ready), 64'd0);
      rdy_m = 1'b1;
      @(negedge clk);

      // Directed immediates with known results.
      cycle(1'b1, 32'h001F_F000, 3'd1, 1'b1, 1'b0);
      chk("d_all_ones", imm, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("d_err0", 64'(imm_err), 64'd0);
      cycle(1'b1, 32'h0077_DDE0, 3'd4, 1'b1, 1'b0);
      chk("iw_hw3_64", imm, 64'hBEEF_0000_0000_0000);
      chk("iw_hw3_32", 64'(imm32), 64'd0);
      cycle(1'b1, 32'h0080_0000, 3'd3, 1'b1, 1'b0);
      chk("cb_neg", imm, 64'hFFFF_FFFF_FFF0_0000);
      cycle(1'b1, 32'h0000_0001, 3'd2, 1'b1, 1'b0);
      chk("b_one", imm, 64'd4);
      cycle(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);

      // Back-pressure: two accepted, third held off until after the first pop.
      cycle(1'b1, 32'h1234_5678, 3'd0, 1'b0, 1'b0);
      cycle(1'b1, 32'h8765_4321, 3'd1, 1'b0, 1'b0);
      chk("full_rdy", 64'(in_ready), 64'd0);
      cycle(1'b1, 32'hDEAD_BEEF, 3'd2, 1'b0, 1'b0);
      cycle(1'b1, 32'hDEAD_BEEF, 3'd2, 1'b1, 1'b0);
      chk("rdy_after_pop", 64'(in_ready), 64'd1);
      cycle(1'b1, 32'hDEAD_BEEF, 3'd2, 1'b1, 1'b0);
      repeat (3) cycle(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);

      // Flush with two entries buffered.
      cycle(1'b1, $urandom, 3'd0, 1'b0, 1'b0);
      cycle(1'b1, $urandom, 3'd3, 1'b0, 1'b0);
      cycle(1'b0, 32'd0, 3'd0, 1'b1, 1'b1);
      chk("flush_empty", 64'(out_valid), 64'd0);

      for (int i = 0; i < 800; i++)
         cycle(1'($urandom % 2), $urandom, 3'($urandom % 8), 1'($urandom % 2),
               ($urandom % 32) == 0);

      // Asynchronous reset with two entries buffered.
      cycle(1'b1, $urandom, 3'd4, 1'b0, 1'b0);
      cycle(1'b1, $urandom, 3'd2, 1'b0, 1'b0);
      cycle(1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_imm",       imm,            64'd0);
      chk("arst_in_ready",  64'(in_ready),  64'd0);
      chk("arst_err_cnt",   64'(err_cnt),   64'd0);
      q.delete();
      errc_m = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rdy_m = 1'b1;
      cycle(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);

      // Saturating illegal-format counter.
      for (int i = 0; i < 300; i++) cycle(1'b1, $urandom, 3'd6, 1'b1, 1'b0);
      chk("err_sat", 64'(err_cnt), 64'd255);
      cycle(1'b1, $urandom, 3'd6, 1'b1, 1'b1);
      chk("err_after_flush", 64'(err_cnt), 64'd255);
      cycle(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
